// File: rtl/led_panel_cmd_ctrl.sv
// UART command parser driving a double-buffered 16x8 LED frame buffer with frame-synchronous bank swap.
// Optional macro FRAME_CHECKSUM_EN adds an XOR checksum byte after each FRAME command.
module led_panel_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [2:0]  RGB_RESET      = 3'b011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       frame_done,
  output logic       fb_we,
  output logic [4:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       disp_bank,
  output logic [2:0] rgb,
  output logic       swap,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0]  SYNC     = 8'hA5;
  localparam logic [7:0]  OP_WRCOL = 8'h01;
  localparam logic [7:0]  OP_COLOR = 8'h02;
  localparam logic [7:0]  OP_FRAME = 8'h03;
  localparam logic [7:0]  OP_SWAP  = 8'h04;
  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_ADDR, S_DATA, S_COLOR, S_FRAME, S_CSUM, S_PEND
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_ADDR, S_DATA, S_COLOR, S_FRAME, S_PEND
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    idx_q, idx_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif
  logic          fb_we_q, fb_we_d;
  logic [4:0]    fb_addr_q, fb_addr_d;
  logic [7:0]    fb_wdata_q, fb_wdata_d;
  logic          disp_bank_q, disp_bank_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          swap_q, swap_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          timed;
  logic          tmo_hit;

  // Only mid-command states wait on the sender; OPC and PEND never time out.
  always_comb begin
    timed = 1'b0;
    case (state_q)
      S_ADDR, S_DATA, S_COLOR, S_FRAME: timed = 1'b1;
`ifdef FRAME_CHECKSUM_EN
      S_CSUM:                           timed = 1'b1;
`endif
      default:                          timed = 1'b0;
    endcase
  end

  assign tmo_hit = timed && !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_valid && rx_byte == SYNC) state_d = S_OPC;
      S_OPC: begin
        if (rx_valid) begin
          case (rx_byte)
            OP_WRCOL: state_d = S_ADDR;
            OP_COLOR: state_d = S_COLOR;
            OP_FRAME: state_d = S_FRAME;
            OP_SWAP:  state_d = S_PEND;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_ADDR:  if (rx_valid) state_d = S_DATA;
      S_DATA:  if (rx_valid) state_d = S_IDLE;
      S_COLOR: if (rx_valid) state_d = S_IDLE;
      S_FRAME: begin
        if (rx_valid && idx_q == 4'd15) begin
`ifdef FRAME_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_PEND;
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CSUM:  if (rx_valid) state_d = (rx_byte == csum_q) ? S_PEND : S_IDLE;
`endif
      S_PEND:  if (busy_q && frame_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end

  always_comb begin
    tmo_d       = (rx_valid || !timed || tmo_hit) ? '0 : tmo_q + 1'b1;
    col_d       = col_q;
    idx_d       = idx_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    disp_bank_d = disp_bank_q;
    rgb_d       = rgb_q;
    swap_d      = 1'b0;
    busy_d      = busy_q;
    err_d       = 1'b0;
    case (state_q)
      S_OPC: begin
        if (rx_valid) begin
          case (rx_byte)
            OP_WRCOL, OP_COLOR: ;
            OP_FRAME: begin
              idx_d  = 4'd0;
`ifdef FRAME_CHECKSUM_EN
              csum_d = 8'h00;
`endif
            end
            OP_SWAP: busy_d = 1'b1;
            default: err_d  = 1'b1;
          endcase
        end
      end
      S_ADDR:  if (rx_valid) col_d = rx_byte[3:0];
      S_DATA: begin
        if (rx_valid) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = {~disp_bank_q, col_q};
          fb_wdata_d = rx_byte;
        end
      end
      S_COLOR: if (rx_valid) rgb_d = rx_byte[2:0];
      S_FRAME: begin
        if (rx_valid) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = {~disp_bank_q, idx_q};
          fb_wdata_d = rx_byte;
          idx_d      = idx_q + 4'd1;
`ifdef FRAME_CHECKSUM_EN
          csum_d     = csum_q ^ rx_byte;
`else
          if (idx_q == 4'd15) busy_d = 1'b1;
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum_q) busy_d = 1'b1;
          else                   err_d  = 1'b1;
        end
      end
`endif
      S_PEND: begin
        // Bytes arriving during a pending swap are overruns and are dropped.
        if (rx_valid) err_d = 1'b1;
        if (busy_q && frame_done) begin
          disp_bank_d = ~disp_bank_q;
          swap_d      = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q       <= '0;
      col_q       <= 4'd0;
      idx_q       <= 4'd0;
`ifdef FRAME_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
      fb_we_q     <= 1'b0;
      fb_addr_q   <= 5'd0;
      fb_wdata_q  <= 8'h00;
      disp_bank_q <= 1'b0;
      rgb_q       <= RGB_RESET;
      swap_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      col_q       <= col_d;
      idx_q       <= idx_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      disp_bank_q <= disp_bank_d;
      rgb_q       <= rgb_d;
      swap_q      <= swap_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign disp_bank = disp_bank_q;
  assign rgb       = rgb_q;
  assign swap      = swap_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_led_panel_cmd_ctrl.sv
// Bench for led_panel_cmd_ctrl: command-level reference model feeds per-output event queues
// that a negedge monitor drains; directed protocol cases followed by randomized byte streams.
module tb_led_panel_cmd_ctrl;

  localparam int         T       = 16;
  localparam logic [2:0] RGB_RST = 3'b011;
  localparam int EV_WR = 0, EV_RGB = 1, EV_ERR = 2, EV_SWAP = 3, EV_BUSY = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       frame_done = 1'b0;
  logic       fb_we;
  logic [4:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       disp_bank;
  logic [2:0] rgb;
  logic       swap;
  logic       busy;
  logic       err;

  led_panel_cmd_ctrl #(.TIMEOUT_CYCLES(T), .RGB_RESET(RGB_RST)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_done(frame_done), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .disp_bank(disp_bank), .rgb(rgb), .swap(swap), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; } evt_t;
  evt_t  exq [5][$];
  string evname [5];
  int    checks = 0;
  int    errors = 0;

  // Reference model: tracks the partially received command as a byte list.
  logic [7:0] cmd [$];
  bit         pending;
  int         pend_e;
  int         last_rx;
  bit         mbank;
  logic [2:0] mrgb;

  function automatic void push(int k, int c, int v);
    evt_t e;
    e.cyc = c;
    e.val = v;
    exq[k].push_back(e);
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    cmd.delete();
    pending = 1'b0;
    pend_e  = 0;
    last_rx = cyc;
    mbank   = 1'b0;
    mrgb    = RGB_RST;
    for (int k = 0; k < 5; k++) exq[k].delete();
  endfunction

  function automatic void enter_pend(int d);
    pending = 1'b1;
    pend_e  = d;
    push(EV_BUSY, d + 1, 1);
  endfunction

  function automatic void wr(int d, logic [3:0] col, logic [7:0] data);
    push(EV_WR, d + 1, int'({~mbank, col, data}));
  endfunction

  function automatic void model_byte(int d, logic [7:0] b);
    int n;
    logic [7:0] x;
    if (pending) begin
      push(EV_ERR, d + 1, 0);
      last_rx = d;
      return;
    end
    if (cmd.size() >= 2 && (d - last_rx) > T) cmd.delete();
    last_rx = d;
    if (cmd.size() == 0) begin
      if (b == 8'hA5) cmd.push_back(b);
    end else if (cmd.size() == 1) begin
      case (b)
        8'h01, 8'h02, 8'h03: cmd.push_back(b);
        8'h04: begin enter_pend(d); cmd.delete(); end
        default: begin push(EV_ERR, d + 1, 0); cmd.delete(); end
      endcase
    end else begin
      cmd.push_back(b);
      case (cmd[1])
        8'h01: if (cmd.size() == 4) begin wr(d, cmd[2][3:0], cmd[3]); cmd.delete(); end
        8'h02: begin
          if (b[2:0] != mrgb) push(EV_RGB, d + 1, int'(b[2:0]));
          mrgb = b[2:0];
          cmd.delete();
        end
        default: begin
          n = cmd.size() - 2;
          if (n <= 16) wr(d, 4'(n - 1), b);
`ifdef FRAME_CHECKSUM_EN
          if (n == 17) begin
            x = 8'h00;
            for (int i = 2; i < 18; i++) x = x ^ cmd[i];
            if (x == b) enter_pend(d);
            else        push(EV_ERR, d + 1, 0);
            cmd.delete();
          end
`else
          x = 8'h00;
          if (n == 16) begin enter_pend(d); cmd.delete(); end
`endif
        end
      endcase
    end
  endfunction

  function automatic void model(int d, bit rv, logic [7:0] b, bit fd);
    bit honour;
    honour = fd && pending && (d > pend_e);
    if (rv) model_byte(d, b);
    if (honour) begin
      mbank   = ~mbank;
      pending = 1'b0;
      push(EV_SWAP, d + 1, int'(mbank));
      push(EV_BUSY, d + 1, 0);
    end
  endfunction

  task automatic step(input bit rv, input logic [7:0] b, input bit fd);
    model(cyc, rv, b, fd);
    rx_valid   = rv;
    rx_byte    = b;
    frame_done = fd;
    @(posedge clk);
    #1;
    rx_valid   = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_fb_we"}, int'(fb_we), 0);
    chk({tag, "_fb_addr"}, int'(fb_addr), 0);
    chk({tag, "_fb_wdata"}, int'(fb_wdata), 0);
    chk({tag, "_disp_bank"}, int'(disp_bank), 0);
    chk({tag, "_rgb"}, int'(rgb), int'(RGB_RST));
    chk({tag, "_swap"}, int'(swap), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic send_frame(input logic [7:0] base);
    send(8'hA5);
    send(8'h03);
    for (int i = 0; i < 16; i++) send(base + 8'(i));
  endtask

  // Monitor: every observed output event must match the head of its queue in value and cycle.
  logic [2:0] prev_rgb;
  logic       prev_busy;
  bit         pres [5];
  int         act [5];
  evt_t       ev;
  always @(negedge clk) begin
    if (reset) begin
      prev_rgb  = rgb;
      prev_busy = busy;
    end else begin
      pres[EV_WR]   = fb_we;             act[EV_WR]   = int'({fb_addr, fb_wdata});
      pres[EV_RGB]  = (rgb != prev_rgb); act[EV_RGB]  = int'(rgb);
      pres[EV_ERR]  = err;               act[EV_ERR]  = 0;
      pres[EV_SWAP] = swap;              act[EV_SWAP] = int'(disp_bank);
      pres[EV_BUSY] = (busy != prev_busy); act[EV_BUSY] = int'(busy);
      for (int k = 0; k < 5; k++) begin
        if (pres[k]) begin
          checks++;
          if (exq[k].size() == 0) begin
            errors++;
            $display("FAIL %s unexpected: got %0h at cyc %0d, required no event", evname[k], act[k], cyc);
          end else begin
            ev = exq[k].pop_front();
            if (ev.cyc != cyc || ev.val != act[k]) begin
              errors++;
              $display("FAIL %s: got %0h at cyc %0d, required %0h at cyc %0d", evname[k], act[k], cyc, ev.val, ev.cyc);
            end
          end
        end else if (exq[k].size() > 0 && exq[k][0].cyc <= cyc) begin
          ev = exq[k].pop_front();
          checks++;
          errors++;
          $display("FAIL %s missing: got none at cyc %0d, required %0h at cyc %0d", evname[k], cyc, ev.val, ev.cyc);
        end
      end
      prev_rgb  = rgb;
      prev_busy = busy;
    end
  end

  initial begin
    int r;
    logic [7:0] b;
    evname[EV_WR] = "write"; evname[EV_RGB] = "rgb"; evname[EV_ERR] = "err";
    evname[EV_SWAP] = "swap"; evname[EV_BUSY] = "busy";
    do_reset();
    idle(2);
    check_reset_values("reset");

    // Single column write, then a full frame with deferred swap.
    send(8'hA5); send(8'h01); send(8'h07); send(8'h3C);
    idle(2);
    send_frame(8'h00);
    idle(2);
    chk("frame_busy", int'(busy), 1);
    step(1'b0, 8'h00, 1'b1);
    idle(1);
    chk("frame_bank", int'(disp_bank), 1);

    // SWAP with an overrun byte before frame_done.
    send(8'hA5); send(8'h04);
    idle(1);
    send(8'h55);
    chk("overrun_busy", int'(busy), 1);
    step(1'b0, 8'h00, 1'b1);
    idle(1);
    chk("swap_bank", int'(disp_bank), 0);

    // frame_done coinciding with the entry byte is ignored.
    send(8'hA5);
    step(1'b1, 8'h04, 1'b1);
    idle(2);
    chk("early_fd_busy", int'(busy), 1);
    step(1'b0, 8'h00, 1'b1);
    idle(1);

    // Colour, unknown opcode, timeout mid-command.
    send(8'hA5); send(8'h02); send(8'h05);
    idle(1);
    chk("color_rgb", int'(rgb), 5);
    send(8'hA5); send(8'h7E);
    send(8'hA5); send(8'hA5);
    send(8'hA5); send(8'h01);
    idle(T + 3);
    send(8'h02); send(8'h3C);
    send(8'hA5); send(8'h03); send(8'h11);
    idle(T + 2);
    send(8'h22);
    idle(2);

`ifdef FRAME_CHECKSUM_EN
    send_frame(8'h00); send(8'h00);
    idle(2);
    chk("csum_ok_busy", int'(busy), 1);
    step(1'b0, 8'h00, 1'b1);
    send_frame(8'h00); send(8'h01);
    idle(3);
    chk("csum_bad_busy", int'(busy), 0);
`endif

    // Randomized byte streams with frame_done noise and occasional long stalls.
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        idle(T + 3);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 25)      b = 8'hA5;
        else if (r < 50) b = 8'($urandom_range(1, 4));
        else if (r < 55) b = 8'h7E;
        else             b = 8'($urandom_range(0, 255));
        step(($urandom_range(0, 99) < 75), b, ($urandom_range(0, 99) < 8));
      end
    end

    // Clear any pending swap, then reset in the middle of a frame.
    idle(2);
    step(1'b0, 8'h00, 1'b1);
    idle(2);
    send(8'hA5); send(8'h03);
    for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)));
    idle(2);
    do_reset();
    idle(1);
    check_reset_values("midframe");
    send(8'hA5); send(8'h01); send(8'h0F); send(8'h81);
    idle(3);

    for (int k = 0; k < 5; k++) chk({"drain_", evname[k]}, exq[k].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
